// File: rtl/dl_arb_mux.sv
// dl_arb_mux: N-input valid/ready arbitrated multiplexer with a registered
// output stage and packet locking. Merges several streaming producers onto
// one downstream channel; a grant is held from the first beat of a packet
// until the beat carrying in_last.
//
// Parameters:
//   NUM_BITS  data width per channel
//   NUM_IN    number of input channels (>= 2, any value)
//   ARB_MODE  0 = round-robin, 1 = fixed priority (lowest index wins)
//   SEL_BITS  derived index width, not overridable
//
// Ports:
//   clk       clock, all state on rising edge
//   rst       synchronous active-high reset
//   in_data   per-channel data
//   in_val    per-channel valid
//   in_last   per-channel end-of-packet marker
//   in_rdy    per-channel ready, at most one bit high
//   out_data  registered data
//   out_last  registered end-of-packet
//   out_sel   registered source channel index
//   out_val   output valid
//   out_rdy   downstream ready
`timescale 1ns/1ps
module dl_arb_mux #(
    parameter  int unsigned NUM_BITS = 32,
    parameter  int unsigned NUM_IN   = 4,
    parameter  int unsigned ARB_MODE = 0,
    localparam int unsigned SEL_BITS = $clog2(NUM_IN)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_IN-1:0][NUM_BITS-1:0] in_data,
    input  logic [NUM_IN-1:0]               in_val,
    input  logic [NUM_IN-1:0]               in_last,
    output logic [NUM_IN-1:0]               in_rdy,
    output logic [NUM_BITS-1:0]             out_data,
    output logic                            out_last,
    output logic [SEL_BITS-1:0]             out_sel,
    output logic                            out_val,
    input  logic                            out_rdy
);

    logic [NUM_BITS-1:0] out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic [SEL_BITS-1:0] out_sel_q,  out_sel_d;
    logic                out_val_q,  out_val_d;
    logic [SEL_BITS-1:0] ptr_q,      ptr_d;
    logic                locked_q,   locked_d;
    logic [SEL_BITS-1:0] lock_ch_q,  lock_ch_d;

    logic                load_en;
    logic                grant_vld;
    logic [SEL_BITS-1:0] grant;
    logic [SEL_BITS:0]   scan_idx;
    logic                accept;

    // Register is free when empty or being drained this cycle.
    assign load_en = ~out_val_q | out_rdy;

    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        scan_idx  = '0;
        if (locked_q) begin
            // Mid-packet: only the owning channel may proceed, even if idle.
            grant_vld = in_val[lock_ch_q];
            grant     = lock_ch_q;
        end else if (ARB_MODE == 1) begin
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (!grant_vld && in_val[i]) begin
                    grant_vld = 1'b1;
                    grant     = SEL_BITS'(i);
                end
            end
        end else begin
            // Scan ptr, ptr+1, ... with an explicit wrap so non-power-of-2
            // channel counts never index past NUM_IN-1.
            for (int unsigned k = 0; k < NUM_IN; k++) begin
                scan_idx = {1'b0, ptr_q} + (SEL_BITS+1)'(k);
                if (scan_idx >= (SEL_BITS+1)'(NUM_IN))
                    scan_idx = scan_idx - (SEL_BITS+1)'(NUM_IN);
                if (!grant_vld && in_val[scan_idx[SEL_BITS-1:0]]) begin
                    grant_vld = 1'b1;
                    grant     = scan_idx[SEL_BITS-1:0];
                end
            end
        end
    end

    always_comb begin
        in_rdy = '0;
        for (int unsigned i = 0; i < NUM_IN; i++)
            in_rdy[i] = load_en & grant_vld & (grant == SEL_BITS'(i));
    end

    // grant_vld already implies in_val[grant].
    assign accept = load_en & grant_vld;

    always_comb begin
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        out_sel_d  = out_sel_q;
        out_val_d  = out_val_q;
        ptr_d      = ptr_q;
        locked_d   = locked_q;
        lock_ch_d  = lock_ch_q;
        if (load_en) begin
            out_val_d = accept;
            if (accept) begin
                out_data_d = in_data[grant];
                out_last_d = in_last[grant];
                out_sel_d  = grant;
                locked_d   = ~in_last[grant];
                lock_ch_d  = grant;
                if (in_last[grant] && ARB_MODE == 0)
                    ptr_d = (grant == SEL_BITS'(NUM_IN - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q <= '0;
            out_last_q <= 1'b0;
            out_sel_q  <= '0;
            out_val_q  <= 1'b0;
            ptr_q      <= '0;
            locked_q   <= 1'b0;
            lock_ch_q  <= '0;
        end else begin
            out_data_q <= out_data_d;
            out_last_q <= out_last_d;
            out_sel_q  <= out_sel_d;
            out_val_q  <= out_val_d;
            ptr_q      <= ptr_d;
            locked_q   <= locked_d;
            lock_ch_q  <= lock_ch_d;
        end
    end

    assign out_data = out_data_q;
    assign out_last = out_last_q;
    assign out_sel  = out_sel_q;
    assign out_val  = out_val_q;

endmodule

// File: tb/tb_dl_arb_mux.sv
`timescale 1ns/1ps
module tb_dl_arb_mux;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic ordy;
    logic [31:0] pat [5];

    // A: 4 inputs round-robin, B: 4 inputs fixed priority, C: 5 inputs round-robin
    logic [3:0][31:0] a_data, b_data;
    logic [4:0][31:0] c_data;
    logic [3:0] a_val, a_last, a_rdy, b_val, b_last, b_rdy;
    logic [4:0] c_val, c_last, c_rdy;
    logic [31:0] a_odata, b_odata, c_odata;
    logic a_olast, b_olast, c_olast;
    logic a_oval, b_oval, c_oval;
    logic [1:0] a_osel, b_osel;
    logic [2:0] c_osel;

    beat_t qa[$], qb[$], qc[$];
    beat_t ea, eb, ec;
    int total = 0;
    int bad = 0;

    dl_arb_mux #(.NUM_BITS(32), .NUM_IN(4), .ARB_MODE(0)) u_a (
        .clk(clk), .rst(rst), .in_data(a_data), .in_val(a_val), .in_last(a_last),
        .in_rdy(a_rdy), .out_data(a_odata), .out_last(a_olast), .out_sel(a_osel),
        .out_val(a_oval), .out_rdy(ordy));

    dl_arb_mux #(.NUM_BITS(32), .NUM_IN(4), .ARB_MODE(1)) u_b (
        .clk(clk), .rst(rst), .in_data(b_data), .in_val(b_val), .in_last(b_last),
        .in_rdy(b_rdy), .out_data(b_odata), .out_last(b_olast), .out_sel(b_osel),
        .out_val(b_oval), .out_rdy(ordy));

    dl_arb_mux #(.NUM_BITS(32), .NUM_IN(5), .ARB_MODE(0)) u_c (
        .clk(clk), .rst(rst), .in_data(c_data), .in_val(c_val), .in_last(c_last),
        .in_rdy(c_rdy), .out_data(c_odata), .out_last(c_olast), .out_sel(c_osel),
        .out_val(c_oval), .out_rdy(ordy));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic push_a(input int s, input logic l);
        beat_t b;
        b.sel = 3'(s); b.data = pat[s]; b.last = l;
        qa.push_back(b);
    endtask

    task automatic push_b(input int s, input logic l);
        beat_t b;
        b.sel = 3'(s); b.data = pat[s]; b.last = l;
        qb.push_back(b);
    endtask

    task automatic push_c(input int s, input logic l);
        beat_t b;
        b.sel = 3'(s); b.data = pat[s]; b.last = l;
        qc.push_back(b);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitors: a beat leaves the DUT on every cycle with out_val & out_rdy.
    always @(negedge clk) begin
        if (a_oval === 1'b1 && ordy === 1'b1) begin
            if (qa.size() == 0) begin
                total++; bad++;
                $display("FAIL a_extra_beat: got sel=%0d data=%0h, expected no beat", a_osel, a_odata);
            end else begin
                ea = qa.pop_front();
                chk("a_sel", 64'(a_osel), 64'(ea.sel));
                chk("a_data", 64'(a_odata), 64'(ea.data));
                chk("a_last", 64'(a_olast), 64'(ea.last));
            end
        end
    end

    always @(negedge clk) begin
        if (b_oval === 1'b1 && ordy === 1'b1) begin
            if (qb.size() == 0) begin
                total++; bad++;
                $display("FAIL b_extra_beat: got sel=%0d data=%0h, expected no beat", b_osel, b_odata);
            end else begin
                eb = qb.pop_front();
                chk("b_sel", 64'(b_osel), 64'(eb.sel));
                chk("b_data", 64'(b_odata), 64'(eb.data));
                chk("b_last", 64'(b_olast), 64'(eb.last));
            end
        end
    end

    always @(negedge clk) begin
        if (c_oval === 1'b1 && ordy === 1'b1) begin
            if (qc.size() == 0) begin
                total++; bad++;
                $display("FAIL c_extra_beat: got sel=%0d data=%0h, expected no beat", c_osel, c_odata);
            end else begin
                ec = qc.pop_front();
                chk("c_sel", 64'(c_osel), 64'(ec.sel));
                chk("c_data", 64'(c_odata), 64'(ec.data));
                chk("c_last", 64'(c_olast), 64'(ec.last));
            end
        end
    end

    initial begin
        pat[0] = 32'h1111_A000;
        pat[1] = 32'h2222_B001;
        pat[2] = 32'h3333_C002;
        pat[3] = 32'h4444_D003;
        pat[4] = 32'h5555_E004;
        for (int i = 0; i < 4; i++) begin
            a_data[i] = pat[i];
            b_data[i] = pat[i];
        end
        for (int i = 0; i < 5; i++) c_data[i] = pat[i];

        rst = 1'b1; ordy = 1'b1;
        a_val = '1; a_last = '1;
        b_val = '0; b_last = '1;
        c_val = '0; c_last = '1;

        // Reset held two cycles with every A channel valid
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) push_a(i % 4, 1'b1);
        #2;
        chk("rst_a_out_val", 64'(a_oval), 64'h0);
        chk("rst_a_out_sel", 64'(a_osel), 64'h0);
        chk("rst_a_in_rdy", 64'(a_rdy), 64'h1);
        chk("rst_b_out_val", 64'(b_oval), 64'h0);
        chk("rst_c_out_val", 64'(c_oval), 64'h0);

        // Round-robin over single-beat packets: 0,1,2,3,0,1,2,3
        repeat (8) @(posedge clk);
        #1;
        a_val = '0;
        cyc();

        // Packet lock on channel 1 with channels 0 and 2 competing
        a_val = 4'b0001; a_last = 4'b1111; push_a(0, 1'b1);
        cyc();
        a_val = 4'b0111; a_last = 4'b1101; push_a(1, 1'b0);
        cyc();
        a_val = 4'b0101;
        #2;
        chk("lock_gap_in_rdy_0", 64'(a_rdy), 64'h0);
        chk("lock_beat1_out_val", 64'(a_oval), 64'h1);
        cyc();
        #2;
        chk("lock_gap_out_val", 64'(a_oval), 64'h0);
        chk("lock_gap_in_rdy_1", 64'(a_rdy), 64'h0);
        cyc();
        a_val = 4'b0111; a_last = 4'b1101; push_a(1, 1'b0);
        #2;
        chk("lock_resume_in_rdy", 64'(a_rdy), 64'h2);
        cyc();
        a_last = 4'b1111; push_a(1, 1'b1);
        cyc();
        a_val = 4'b0101; push_a(2, 1'b1);
        #2;
        chk("unlock_next_in_rdy", 64'(a_rdy), 64'h4);
        cyc();
        a_val = '0;
        cyc();

        // Backpressure: hold a channel-3 beat for 5 cycles
        a_val = '1; a_last = '1; push_a(3, 1'b1);
        cyc();
        ordy = 1'b0;
        repeat (5) begin
            cyc();
            #2;
            chk("bp_out_val", 64'(a_oval), 64'h1);
            chk("bp_out_sel", 64'(a_osel), 64'h3);
            chk("bp_out_data", 64'(a_odata), 64'(pat[3]));
            chk("bp_in_rdy", 64'(a_rdy), 64'h0);
        end
        ordy = 1'b1; push_a(0, 1'b1);
        #1;
        chk("bp_release_in_rdy", 64'(a_rdy), 64'h1);
        cyc();
        a_val = '0;
        #2;
        chk("bp_nobubble_val", 64'(a_oval), 64'h1);
        chk("bp_nobubble_sel", 64'(a_osel), 64'h0);
        cyc();

        // Reset mid-packet: channel 2 locked, its beat stuck in the register
        a_val = 4'b0100; a_last = 4'b1011;
        cyc();
        ordy = 1'b0; rst = 1'b1;
        a_val = 4'b0101; a_last = 4'b1111;
        cyc();
        rst = 1'b0; ordy = 1'b1; push_a(0, 1'b1);
        #2;
        chk("midrst_out_val", 64'(a_oval), 64'h0);
        chk("midrst_in_rdy", 64'(a_rdy), 64'h1);
        cyc();
        a_val = '0;
        cyc();

        // Fixed priority: channels 0 and 3 valid, channel 0 every beat
        b_val = 4'b1001; b_last = '1;
        for (int i = 0; i < 4; i++) push_b(0, 1'b1);
        #2;
        chk("fp_in_rdy", 64'(b_rdy), 64'h1);
        repeat (4) cyc();
        b_val = '0;
        cyc();

        // Five inputs, channels 4 and 0 valid: pointer wraps 4 -> 0
        c_val = 5'b10001; c_last = '1;
        push_c(0, 1'b1); push_c(4, 1'b1); push_c(0, 1'b1); push_c(4, 1'b1);
        repeat (4) cyc();
        c_val = '0;
        repeat (3) cyc();

        chk("qa_drained", 64'(qa.size()), 64'h0);
        chk("qb_drained", 64'(qb.size()), 64'h0);
        chk("qc_drained", 64'(qc.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
